// File: rtl/input_skew.sv
// Diagonal skew between unified-buffer rows and the systolic array west edge.
// Latency: lane i of a row accepted at edge k is presented after edge k+1+i.
// No backpressure: every chain shifts every cycle; rows arrive only via in_valid in FILL.
module input_skew #(
  parameter int data_width   = 8,
  parameter int width_height = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 active,
  input  logic [$clog2(width_height):0]        num_row,
  input  logic [data_width*width_height-1:0]   in_data,
  input  logic                                 in_valid,
  output logic [data_width*width_height-1:0]   out_data,
  output logic [width_height-1:0]              out_valid,
  output logic                                 busy,
  output logic                                 done
);

  localparam int CW = $clog2(width_height) + 1;
  localparam int DC = $clog2(width_height);
  localparam logic [DC-1:0] DRAIN_LOAD = DC'(width_height - 2);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   num_lat;
  logic [CW-1:0]   row_cnt;
  logic [CW-1:0]   row_nxt;
  logic [DC-1:0]   drain_cnt;
  logic            take;

  assign take    = (state == FILL) && in_valid;
  assign row_nxt = row_cnt + CW'(1);

  // busy/done lag the state by one cycle so done lines up with the last lane.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      num_lat   <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state == FILL) || (state == DRAIN);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (active) begin
            num_lat <= num_row;
            row_cnt <= '0;
            state   <= (num_row == '0) ? DONE : FILL;
          end
        end
        FILL: begin
          if (in_valid) begin
            row_cnt <= row_nxt;
            if (row_nxt == num_lat) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) state <= DONE;
          else                 drain_cnt <= drain_cnt - DC'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < width_height; i++) begin : g_lane
    logic [data_width-1:0] dat_q [i+1];
    logic [i:0]            vld_q;
    logic [data_width-1:0] out_dat_q;
    logic                  out_vld_q;

    // Empty slots carry zero data so the array never sees stale operands.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int s = 0; s <= i; s++) dat_q[s] <= '0;
        vld_q     <= '0;
        out_dat_q <= '0;
        out_vld_q <= 1'b0;
      end else begin
        dat_q[0] <= take ? in_data[i*data_width +: data_width] : '0;
        vld_q[0] <= take;
        for (int s = 1; s <= i; s++) begin
          dat_q[s] <= dat_q[s-1];
          vld_q[s] <= vld_q[s-1];
        end
        out_dat_q <= dat_q[i];
        out_vld_q <= vld_q[i];
      end
    end

    assign out_data[i*data_width +: data_width] = out_dat_q;
    assign out_valid[i]                         = out_vld_q;
  end

endmodule

// File: doc/input_skew.md
# input_skew

Diagonal skew stage between the unified-buffer read port and the west edge of the systolic array. The master memory controller broadcasts one row address per cycle, so the buffer returns a full `width_height`-lane row each cycle. This block delays lane i by i extra cycles so that operands enter the array on the wavefront diagonal. It counts rows against the same `num_row` programmed into the memory controller and reports completion once the last row has fully drained out of the widest lane.

## Interface
- `data_width`, 8, bits per lane element
- `width_height`, 16, number of lanes (array edge size); must be >= 2

- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `active`  in  1  start pulse; sampled only in IDLE
- `num_row`  in  $clog2(width_height)+1  rows to accept this pass; latched on start
- `in_data`  in  data_width*width_height  row from buffer; lane i = bits [i*data_width +: data_width]
- `in_valid`  in  1  in_data carries a row this cycle
- `out_data`  out  data_width*width_height  skewed lanes to array, same lane packing
- `out_valid`  out  width_height  per-lane valid
- `busy`  out  1  high in FILL and DRAIN
- `done`  out  1  one-cycle completion pulse

## Operation
- Reset (`reset`=0, async): state=IDLE, all delay registers, `out_data`, `out_valid`, `busy`, `done`, counters = 0.
- Lane i is a register chain of depth i+1. Each stage carries data plus a valid bit. All chains shift every cycle, regardless of state.
- Chain input in FILL: `in_data` lane i and `in_valid`. In IDLE/DRAIN: data 0, valid 0.
- Invalid slots always carry zero data, so `out_data` lane i is 0 whenever `out_valid[i]`=0.
- States:
  - IDLE: on `active`=1, latch `num_row` and clear `row_cnt`. If latched num_row=0, go to DONE. Otherwise go to FILL.
  - FILL: each cycle with `in_valid`=1, `row_cnt`+=1. Gaps (`in_valid`=0) propagate as bubbles. When the accepted row is number num_row, go to DRAIN and load `drain_cnt`=width_height-2.
  - DRAIN: `in_valid` ignored. `drain_cnt` decrements each cycle. At 0, go to DONE.
  - DONE: one cycle, `done`=1, then IDLE.
- `busy`=1 in FILL and DRAIN only.
- `active` outside IDLE is ignored. `in_valid` outside FILL is ignored (data dropped, not counted).
- `num_row` may exceed width_height (up to 2*width_height-1). Counting is identical in that case.
- Reset asserted mid-operation aborts immediately. No `done` pulse; chains flushed.

## Timing
- Start latency: `active` sampled at edge E → FILL from cycle after E. The first row can be accepted at edge E+1.
- Row accepted at edge k:
  - lane 0 appears on `out_data`/`out_valid[0]` after edge k+1;
  - lane i appears after edge k+1+i;
  - each lane holds for exactly one cycle.
- Last row accepted at edge k:
  - DRAIN spans edges k+1..k+width_height-1;
  - `done`=1 during the cycle after edge k+width_height, coincident with that row's final `out_valid[width_height-1]`.
- num_row=0: `done`=1 the cycle after the DONE transition, i.e. after edge E+1. No valid outputs.
- `done` and `busy` are registered outputs. `done` and `busy` are never both high.

## Test plan
- Reset: hold `reset`=0 with random `in_data`/`in_valid` → all outputs 0. Release and idle 10 cycles → outputs stay 0.
- Basic skew (width_height=4, data_width=8), num_row=4:
  - stimulus: rows r=0..3 back-to-back, lane i value = 16*r+i;
  - required: lane i shows 16*r+i exactly at cycle k_r+1+i;
  - required: `done` pulses once, aligned with lane 3 of row 3; `busy` high from E+1 until the cycle before `done`.
- Bubbles: num_row=3 with `in_valid` pattern 1,0,1,0,1 → three rows emerge with one-cycle gaps per lane. Gap slots show data 0 and valid 0. `done` is delayed by the 2 bubble cycles.
- Ignored inputs:
  - `active` pulsed during FILL → no restart, `row_cnt` unchanged;
  - `in_valid`=1 during DRAIN → no extra output rows.
- num_row=0: `done` after E+1, `out_valid` stays 0. num_row=7 (> width_height=4): seven rows counted, `done` after 7th row drains.
- Reset mid-DRAIN: assert `reset` two cycles into DRAIN → outputs 0 asynchronously, no `done`. A new pass afterwards runs correctly.
